// File: rtl/top.sv
// rtl/top.sv - self-contained dot-product engine: pipelined MAC over constant vectors, nibble-serial result display
module top #(
    parameter int VEC_LEN = 8,
    parameter int DW      = 4,
    parameter int ACC_W   = 12
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] out
);
    localparam int IDX_W = 4;
    localparam int NIB   = ACC_W / 4;
    localparam int PTR_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [2*DW-1:0]    prod_q, prod_d;
    logic               prod_v_q, prod_v_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [3:0]         out_q, out_d;

    logic [DW-1:0]      a_op, b_op;

    // Operands are generated from the index rather than stored: A[i]=i+1, B[i]=VEC_LEN-i.
    assign a_op = DW'({1'b0, idx_q} + 5'd1);
    assign b_op = DW'(5'(VEC_LEN) - {1'b0, idx_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            acc_q    <= '0;
            ptr_q    <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            prod_q   <= prod_d;
            prod_v_q <= prod_v_d;
            acc_q    <= acc_d;
            ptr_q    <= ptr_d;
            out_q    <= out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        prod_d   = prod_q;
        prod_v_d = prod_v_q;
        acc_d    = acc_q;
        ptr_d    = ptr_q;
        out_d    = 4'd0;

        // Accumulate stage runs independently of state, one cycle behind the multiplier.
        if (prod_v_q) begin
            acc_d = acc_q + ACC_W'(prod_q);
        end

        unique case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                prod_d   = {{DW{1'b0}}, a_op} * {{DW{1'b0}}, b_op};
                prod_v_d = 1'b1;
                if (idx_q == IDX_W'(VEC_LEN - 1)) begin
                    idx_d   = '0;
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: begin
                prod_v_d = 1'b0;
                state_d  = DONE;
            end
            DONE: begin
                out_d = acc_q[4*ptr_q +: 4];
                if (ptr_q == PTR_W'(NIB - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out = out_q;

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - scoreboard bench for the dot-product engine across three parameter sets
module tb_top;
    logic       clk;
    logic       rst0, rst1, rst15;
    logic [3:0] out0, out1, out15;

    int checks;
    int passed;
    logic [3:0] exp_q[$];

    top dut0 (
        .clk (clk),
        .rst (rst0),
        .out (out0)
    );

    top #(.VEC_LEN(1), .DW(4), .ACC_W(12)) dut1 (
        .clk (clk),
        .rst (rst1),
        .out (out1)
    );

    top #(.VEC_LEN(15), .DW(4), .ACC_W(12)) dut15 (
        .clk (clk),
        .rst (rst15),
        .out (out15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected display after edge k (E1 = first edge with reset low).
    function automatic logic [3:0] exp_nib(int k, int vec, logic [11:0] res);
        int p;
        if (k < vec + 3) return 4'd0;
        p = (k - (vec + 3)) % 3;
        return res[4*p +: 4];
    endfunction

    task automatic test_reset();
        logic [3:0] e;
        rst0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(4'd0);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (out0 !== e) $display("FAIL reset_out cyc%0d: got %h want %h", k, out0, e);
            else passed++;
        end
        checks++;
        if (dut0.acc_q !== 12'd0) $display("FAIL reset_acc: got %h want 000", dut0.acc_q);
        else passed++;
    endtask

    task automatic test_default_run();
        logic [3:0] e;
        rst0 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            exp_q.push_back(exp_nib(k, 8, 12'h078));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (out0 !== e) $display("FAIL default_E%0d: got %h want %h", k, out0, e);
            else passed++;
        end
        checks++;
        if (dut0.acc_q !== 12'd120) $display("FAIL default_acc: got %0d want 120", dut0.acc_q);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] e;
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back(exp_nib(k, 8, 12'h078));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (out0 !== e) $display("FAIL midrun_pre_E%0d: got %h want %h", k, out0, e);
            else passed++;
        end
        rst0 = 1'b1;
        exp_q.push_back(4'd0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (out0 !== e) $display("FAIL midrun_rst_out: got %h want %h", out0, e);
        else passed++;
        checks++;
        if (dut0.acc_q !== 12'd0) $display("FAIL midrun_rst_acc: got %h want 000", dut0.acc_q);
        else passed++;
        rst0 = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            exp_q.push_back(exp_nib(k, 8, 12'h078));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (out0 !== e) $display("FAIL midrun_post_E%0d: got %h want %h", k, out0, e);
            else passed++;
        end
    endtask

    task automatic test_reset_in_done();
        logic [3:0] e;
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            exp_q.push_back(exp_nib(k, 8, 12'h078));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (out0 !== e) $display("FAIL done_pre_E%0d: got %h want %h", k, out0, e);
            else passed++;
        end
        rst0 = 1'b1;
        exp_q.push_back(4'd0);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (out0 !== e) $display("FAIL done_rst_out: got %h want %h", out0, e);
        else passed++;
        rst0 = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            exp_q.push_back(exp_nib(k, 8, 12'h078));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (out0 !== e) $display("FAIL done_post_E%0d: got %h want %h", k, out0, e);
            else passed++;
        end
    endtask

    task automatic test_vec1();
        logic [3:0] e;
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            exp_q.push_back(exp_nib(k, 1, 12'h001));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (out1 !== e) $display("FAIL vec1_E%0d: got %h want %h", k, out1, e);
            else passed++;
        end
        checks++;
        if (dut1.acc_q !== 12'd1) $display("FAIL vec1_acc: got %0d want 1", dut1.acc_q);
        else passed++;
    endtask

    task automatic test_vec15();
        logic [3:0] e;
        rst15 = 1'b1;
        @(posedge clk); #1;
        rst15 = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            exp_q.push_back(exp_nib(k, 15, 12'h2A8));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (out15 !== e) $display("FAIL vec15_E%0d: got %h want %h", k, out15, e);
            else passed++;
        end
        checks++;
        if (dut15.acc_q !== 12'd680) $display("FAIL vec15_acc: got %0d want 680", dut15.acc_q);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst0   = 1'b1;
        rst1   = 1'b1;
        rst15  = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_default_run();
        test_reset_mid_run();
        test_reset_in_done();
        test_vec1();
        test_vec15();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/top.md
# top

Top-level wrapper of the accelerator: a self-contained dot-product engine with no data inputs. It holds two constant operand vectors, runs a pipelined multiply-accumulate over them after reset, then shows the accumulated result on a 4-bit output, one nibble per cycle. It is the root of the design hierarchy and is driven only by clock and reset.

## Interface
- Clock and reset: one clock; reset is synchronous and active-high.
- Parameters:
  - `VEC_LEN`, default 8: vector length. Legal range 1..15.
  - `DW`, default 4: operand width in bits. Operands are unsigned.
  - `ACC_W`, default 12: accumulator width. Must be a multiple of 4.
- Ports:
  - `clk`, input, 1: system clock. All logic updates on the rising edge.
  - `rst`, input, 1: synchronous active-high reset.
  - `out`, output, 4: registered result-nibble display.

## Operation
- Operand constants, for index i = 0..VEC_LEN-1:
  - A[i] = i+1
  - B[i] = VEC_LEN-i
  - Both are truncated to DW bits.
  - With defaults: A = 1..8 and B = 8..1.
- State machine states: IDLE, RUN, DRAIN, DONE.
- IDLE: on the first edge with rst low, go to RUN.
- RUN:
  - On each edge, register prod_r <= A[idx]*B[idx]. The product is 2*DW bits, unsigned.
  - Set prod_v <= 1 and increment idx.
  - On the edge that issues idx = VEC_LEN-1, go to DRAIN and clear idx to 0.
- Accumulate stage: on any edge with prod_v = 1, acc <= acc + zero-extended prod_r, modulo 2^ACC_W. No saturation.
- DRAIN:
  - Lasts one cycle. prod_v <= 0, and the final product is accumulated on this edge.
  - Next state is DONE.
- DONE:
  - Holds until reset.
  - Each edge: out <= acc[4*ptr+3 : 4*ptr].
  - ptr counts 0, 1, ..., ACC_W/4-1, then wraps to 0.
- `out` is 0 in every state except DONE. The displayed nibbles are registered from acc and ptr.
- Default result: sum of A[i]*B[i] = 120 = 0x078. The out sequence is 8, 7, 0, 8, 7, 0, ...

## Timing
- Reset clears all of the following on the edge: state = IDLE, idx = 0, prod_r = 0, prod_v = 0, acc = 0, ptr = 0, out = 0.
- Reset takes priority over every other action.
- Edge numbering: E1 is the first edge with rst low.
  - E1: IDLE -> RUN.
  - E2 .. E(VEC_LEN+1): products issued.
  - E3 .. E(VEC_LEN+2): accumulations. The final accumulation is on the DRAIN edge.
  - E(VEC_LEN+2): DRAIN -> DONE.
  - First nonzero-display edge: E(VEC_LEN+3). With defaults, out = 8 after E11, 7 after E12, 0 after E13, 8 after E14.
- Total latency from reset release to the first result nibble: VEC_LEN+3 cycles.
- Reset asserted mid-RUN or mid-DONE: everything clears on that edge. The computation restarts from E1 after release and gives the identical result.
- VEC_LEN = 1: RUN lasts one edge, then DRAIN, then DONE. Result is A[0]*B[0] = 1.

## Test plan
- Default parameters, hold rst high for 3 cycles -> out = 0 throughout. Internal acc = 0.
- Release rst, run 20 cycles -> out = 0 through E10. Then 8 at E11, 7 at E12, 0 at E13, 8 at E14, continuing cyclically. acc = 120.
- Reassert rst for 1 cycle at E6 (mid-RUN) -> out and acc = 0 on that edge. After release, the same 8/7/0 sequence starts exactly VEC_LEN+3 edges later.
- Reset during DONE at E15 -> out = 0 on that edge. The sequence restarts at 8 after 11 edges.
- VEC_LEN = 1 -> out sequence 1, 0, 0, 1, 0, 0 starting at E4.
- VEC_LEN = 15, ACC_W = 12 -> acc = sum of (i+1)(15-i) over i = 0..14, with operands truncated to DW = 4 bits. A[i] = 16 -> 0 does not occur since i+1 ≤ 15. acc = 680 = 0x2A8, so out sequence is 8, A, 2 starting at E18.
